// File: rtl/vector_pkg.sv
// Shared types and constants for the vector execute/memory pipeline boundary.
package vector_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned LANES      = 6;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned RES_W      = DATA_WIDTH * LANES;

    typedef logic [DATA_WIDTH-1:0] vec_lane_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } vec_wb_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/vector_ex_mem_stage_if.sv
// Upstream beat, downstream head and forwarding bus of the EX/MEM boundary.
interface vector_ex_mem_stage_if;
    import vector_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [RES_W-1:0]      in_result;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  in_reg_write;
    logic                  in_mem_read;
    logic                  in_mem_write;

    logic                  out_valid;
    logic                  out_ready;
    logic [RES_W-1:0]      out_result;
    logic [REG_ADDR_W-1:0] out_dest;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic [LANES-1:0]      out_lane_zero;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_dest;
    logic [RES_W-1:0]      fwd_data;

    // master drives beats in and consumes the head; slave is the stage itself
    modport master (
        output in_valid, in_result, in_dest, in_reg_write, in_mem_read, in_mem_write,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_dest, out_reg_write, out_mem_read, out_mem_write,
        input  out_lane_zero, fwd_valid, fwd_dest, fwd_data
    );

    modport slave (
        input  in_valid, in_result, in_dest, in_reg_write, in_mem_read, in_mem_write,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_dest, out_reg_write, out_mem_read, out_mem_write,
        output out_lane_zero, fwd_valid, fwd_dest, fwd_data
    );
endinterface

// File: rtl/vector_stage_entry.sv
// One storage slot of the skid buffer: load-enabled result + write-back control.
module vector_stage_entry
    import vector_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [RES_W-1:0] i_result,
    input  vec_wb_ctrl_t     i_ctrl,
    output logic [RES_W-1:0] o_result,
    output vec_wb_ctrl_t     o_ctrl
);

    logic [RES_W-1:0] r_result;
    vec_wb_ctrl_t     r_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_ctrl   <= '0;
        end else if (i_load) begin
            r_result <= i_result;
            r_ctrl   <= i_ctrl;
        end
    end

    assign o_result = r_result;
    assign o_ctrl   = r_ctrl;

endmodule

// File: rtl/vector_ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer, flush and operand forwarding.
module vector_ex_mem_stage
    import vector_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    vector_ex_mem_stage_if.slave   bus
);

    stage_state_t     r_state;
    stage_state_t     w_state_next;
    logic             r_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_head_load;
    logic             w_skid_load;
    logic             w_head_from_skid;
    logic [RES_W-1:0] w_head_result;
    logic [RES_W-1:0] w_skid_result;
    logic [RES_W-1:0] w_head_din_result;
    vec_wb_ctrl_t     w_head_ctrl;
    vec_wb_ctrl_t     w_skid_ctrl;
    vec_wb_ctrl_t     w_in_ctrl;
    vec_wb_ctrl_t     w_head_din_ctrl;
    vec_lane_t        w_head_lanes [LANES];
    logic [LANES-1:0] w_lane_zero;

    assign w_in_ctrl = '{dest:      bus.in_dest,
                         reg_write: bus.in_reg_write,
                         mem_read:  bus.in_mem_read,
                         mem_write: bus.in_mem_write};

    assign w_push = bus.in_valid & r_in_ready;
    assign w_pop  = (r_state != EMPTY) & bus.out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_head_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_head_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_next = ONE;
                    w_head_load  = 1'b1;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_head_load = 1'b1;
                end else if (w_push) begin
                    w_state_next = FULL;
                    w_skid_load  = 1'b1;
                end else if (w_pop) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_state_next     = ONE;
                    w_head_load      = 1'b1;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_next = EMPTY;
        endcase
        // flush wins over any simultaneous push/pop; the incoming beat is dropped
        if (flush) begin
            w_state_next = EMPTY;
            w_head_load  = 1'b0;
            w_skid_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != FULL);
        end
    end

    assign w_head_din_result = w_head_from_skid ? w_skid_result : bus.in_result;
    assign w_head_din_ctrl   = w_head_from_skid ? w_skid_ctrl   : w_in_ctrl;

    vector_stage_entry u_head (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_head_load),
        .i_result (w_head_din_result),
        .i_ctrl   (w_head_din_ctrl),
        .o_result (w_head_result),
        .o_ctrl   (w_head_ctrl)
    );

    vector_stage_entry u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_skid_load),
        .i_result (bus.in_result),
        .i_ctrl   (w_in_ctrl),
        .o_result (w_skid_result),
        .o_ctrl   (w_skid_ctrl)
    );

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_head_lanes[gi] = w_head_result[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // lane-zero flags only mean something for a valid head, so they read 0 when empty
    always_comb begin
        w_lane_zero = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_zero[i] = (r_state != EMPTY) && (w_head_lanes[i] == '0);
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = (r_state != EMPTY);
    assign bus.out_result    = w_head_result;
    assign bus.out_dest      = w_head_ctrl.dest;
    assign bus.out_reg_write = w_head_ctrl.reg_write;
    assign bus.out_mem_read  = w_head_ctrl.mem_read;
    assign bus.out_mem_write = w_head_ctrl.mem_write;
    assign bus.out_lane_zero = w_lane_zero;

    always_comb begin
        bus.fwd_valid = 1'b0;
        bus.fwd_dest  = '0;
        bus.fwd_data  = '0;
        case (r_state)
            ONE: begin
                bus.fwd_valid = w_head_ctrl.reg_write;
                bus.fwd_dest  = w_head_ctrl.dest;
                bus.fwd_data  = w_head_result;
            end
            FULL: begin
                bus.fwd_valid = w_skid_ctrl.reg_write;
                bus.fwd_dest  = w_skid_ctrl.dest;
                bus.fwd_data  = w_skid_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vector_ex_mem_stage.sv
// Directed and random bench for vector_ex_mem_stage against a queue-based reference model.
`timescale 1ns/1ps
module tb_vector_ex_mem_stage;
    import vector_pkg::*;

    typedef struct {
        logic [RES_W-1:0]      res;
        logic [REG_ADDR_W-1:0] dest;
        logic                  rw;
        logic                  mr;
        logic                  mw;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    beat_t exp_q[$];

    vector_ex_mem_stage_if bus ();

    vector_ex_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LANES-1:0] model_lane_zero(input logic [RES_W-1:0] r);
        logic [LANES-1:0] z;
        for (int i = 0; i < LANES; i++) z[i] = (r[i*DATA_WIDTH +: DATA_WIDTH] == 0);
        return z;
    endfunction

    // Reference model: the stage is a FIFO of depth 2 that empties on flush or reset.
    always @(negedge rst_n) exp_q.delete();

    always begin
        beat_t nb;
        beat_t y;
        logic  m_push, m_pop;
        @(negedge clk);
        #5;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            if (exp_q.size() > 0) begin
                y = exp_q[exp_q.size()-1];
                check("out_result", 64'(bus.out_result), 64'(exp_q[0].res));
                check("out_ctrl", 64'({bus.out_dest, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}),
                      64'({exp_q[0].dest, exp_q[0].rw, exp_q[0].mr, exp_q[0].mw}));
                check("out_lane_zero", 64'(bus.out_lane_zero), 64'(model_lane_zero(exp_q[0].res)));
                check("fwd", 64'({bus.fwd_valid, bus.fwd_dest}), 64'({y.rw, y.dest}));
                check("fwd_data", 64'(bus.fwd_data), 64'(y.res));
            end else begin
                check("fwd_empty", 64'({bus.fwd_valid, bus.fwd_dest}), 64'd0);
                check("fwd_data_empty", 64'(bus.fwd_data), 64'd0);
            end
            m_pop  = (exp_q.size() > 0) && bus.out_ready;
            m_push = bus.in_valid && (exp_q.size() < 2);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) begin
                    nb.res  = bus.in_result;
                    nb.dest = bus.in_dest;
                    nb.rw   = bus.in_reg_write;
                    nb.mr   = bus.in_mem_read;
                    nb.mw   = bus.in_mem_write;
                    exp_q.push_back(nb);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [RES_W-1:0] r, input logic [REG_ADDR_W-1:0] d,
                         input logic rw, input logic mr, input logic mw, input logic ordy, input logic fl);
        @(negedge clk);
        #1;
        bus.in_valid     = v;
        bus.in_result    = r;
        bus.in_dest      = d;
        bus.in_reg_write = rw;
        bus.in_mem_read  = mr;
        bus.in_mem_write = mw;
        bus.out_ready    = ordy;
        flush            = fl;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    logic [RES_W-1:0] stream_res [4];

    initial begin
        stream_res[0] = 48'h000102030405;
        stream_res[1] = 48'h000A0B0C0D0E;
        stream_res[2] = 48'h00141516171A;
        stream_res[3] = 48'h001E1F202122;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_dest = '0;
        bus.in_reg_write = 1'b0; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);

        // streaming: back-to-back beats, each visible one cycle after acceptance
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream_res[i], REG_ADDR_W'(i+1), 1'b1, i[0], 1'b0, 1'b1, 1'b0);
            after_edge();
            check("stream_dest", 64'(bus.out_dest), 64'(i+1));
            check("stream_result", 64'(bus.out_result), 64'(stream_res[i]));
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
        end
        idle(1'b1, 2);

        // backpressure into the skid entry, then a single pop
        drive(1'b1, 48'h333333333333, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 48'h555555555555, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 48'h777777777777, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_head_dest", 64'(bus.out_dest), 64'd3);
        check("bp_fwd_dest", 64'(bus.fwd_dest), 64'd5);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        check("bp_pop_dest", 64'(bus.out_dest), 64'd5);
        check("bp_pop_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1'b1, 2);

        // flush while full with a simultaneous push and pop
        drive(1'b1, 48'h0000000000A1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 48'h0000000000A2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 48'hDEADBEEF0099, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        after_edge();
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1'b1, 3);
        check("flush_dropped", 64'(bus.out_valid), 64'd0);

        // lane-zero flags, then a non-writing youngest beat
        drive(1'b1, 48'h110022330044, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("lane_zero", 64'(bus.out_lane_zero), 64'b010010);
        drive(1'b1, 48'h010203040506, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        after_edge();
        check("fwd_no_write", 64'(bus.fwd_valid), 64'd0);
        check("fwd_no_write_dest", 64'(bus.fwd_dest), 64'd7);

        // asynchronous reset mid-cycle while full
        @(negedge clk);
        #7 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_in_ready", 64'(bus.in_ready), 64'd1);
        check("async_fwd", 64'({bus.fwd_valid, bus.fwd_dest}), 64'd0);
        check("async_out_result", 64'(bus.out_result), 64'd0);
        check("async_out_ctrl", 64'({bus.out_dest, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_lane_zero}), 64'd0);
        idle(1'b0, 1);
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  REG_ADDR_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        idle(1'b1, 4);
        #10;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
